// File: rtl/pipe_pkg.sv
// Shared control-path types for the 5-stage RV32I pipeline: opcode classes,
// select encodings, the per-stage control word and its bubble value.
package pipe_pkg;

  localparam int unsigned REG_AW  = 5;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned IMMS_W  = 5;

  localparam logic [4:0] OPC_R     = 5'b01100;
  localparam logic [4:0] OPC_LOAD  = 5'b00000;
  localparam logic [4:0] OPC_OPIMM = 5'b00100;
  localparam logic [4:0] OPC_S     = 5'b01000;
  localparam logic [4:0] OPC_B     = 5'b11000;
  localparam logic [4:0] OPC_JAL   = 5'b11011;
  localparam logic [4:0] OPC_JALR  = 5'b11001;
  localparam logic [4:0] OPC_LUI   = 5'b01101;

  localparam logic [IMMS_W-1:0] IMM_NONE = 5'b00000;
  localparam logic [IMMS_W-1:0] IMM_I    = 5'b00001;
  localparam logic [IMMS_W-1:0] IMM_S    = 5'b00010;
  localparam logic [IMMS_W-1:0] IMM_B    = 5'b00100;
  localparam logic [IMMS_W-1:0] IMM_U    = 5'b01000;
  localparam logic [IMMS_W-1:0] IMM_J    = 5'b10000;

  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  localparam logic [OP_W-1:0] ALU_ADD = 4'b0000;
  localparam logic [OP_W-1:0] ALU_LUI = 4'b1001;

  typedef struct packed {
    logic              valid;
    logic              asel;
    logic              bsel;
    logic              brun;
    logic [OP_W-1:0]   op;
    logic              wren;
    logic [2:0]        rwsel;
    logic              regwen;
    logic [1:0]        wbsel;
    logic [REG_AW-1:0] rd;
    logic              is_load;
    logic              is_jump;
    logic              is_branch;
    logic [2:0]        funct3;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // x0 never matches: unused sources are presented as 0 and regwen implies rd != 0
  function automatic logic rd_match(input logic [REG_AW-1:0] rs, input ctrl_t c);
    return (rs != '0) && c.valid && c.regwen && (c.rd == rs);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                         input ctrl_t m, input ctrl_t w);
    if (rd_match(rs, m) && !m.is_load) return FWD_EXMEM;
    if (rd_match(rs, w)) return FWD_MEMWB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_ctrl_decode.sv
// ctrl_decode: combinational ID-stage decoder from a raw instruction to the
// pipeline control word, immediate select and used source addresses.
module ctrl_decode
  import pipe_pkg::*;
#(
  parameter int unsigned REGW = 5
) (
  input  logic [31:0]       instr_i,
  input  logic              valid_i,
  output ctrl_t             ctrl_o,
  output logic [IMMS_W-1:0] immsel_o,
  output logic [REG_AW-1:0] rs1_o,
  output logic [REG_AW-1:0] rs2_o
);

  logic [4:0]        opc;
  logic [2:0]        f3;
  logic [REG_AW-1:0] rd, rs1, rs2;
  logic is_r, is_i, is_s, is_b, is_jal, is_jalr, is_u;
  logic unused_bits;

  assign opc     = instr_i[6:2];
  assign f3      = instr_i[14:12];
  assign rd      = REG_AW'(instr_i[7 +: REGW]);
  assign rs1     = REG_AW'(instr_i[15 +: REGW]);
  assign rs2     = REG_AW'(instr_i[20 +: REGW]);
  assign is_r    = (opc == OPC_R);
  assign is_i    = (opc[4:3] == 2'b00) && (opc[1:0] == 2'b00);
  assign is_s    = (opc == OPC_S);
  assign is_b    = (opc == OPC_B);
  assign is_jal  = (opc == OPC_JAL);
  assign is_jalr = (opc == OPC_JALR);
  assign is_u    = ({opc[4], opc[2:0]} == 4'b0101);

  assign unused_bits = ^{instr_i[31], instr_i[29:25], instr_i[1:0]};

  // immediate select follows the instruction regardless of valid
  always_comb begin
    immsel_o = IMM_NONE;
    if (is_i || is_jalr) immsel_o = IMM_I;
    else if (is_s)       immsel_o = IMM_S;
    else if (is_b)       immsel_o = IMM_B;
    else if (is_u)       immsel_o = IMM_U;
    else if (is_jal)     immsel_o = IMM_J;
  end

  always_comb begin
    ctrl_o = CTRL_BUBBLE;
    rs1_o  = '0;
    rs2_o  = '0;
    if (valid_i) begin
      ctrl_o.valid     = 1'b1;
      ctrl_o.asel      = is_b | is_jal | is_u;
      ctrl_o.bsel      = ~is_r;
      ctrl_o.brun      = f3[1];
      ctrl_o.wren      = is_s;
      ctrl_o.rwsel     = f3;
      ctrl_o.regwen    = ~is_b & ~is_s & (rd != '0);
      ctrl_o.wbsel     = (is_jal | is_jalr) ? WB_PC4 :
                         (opc == OPC_LOAD)  ? WB_MEM : WB_ALU;
      ctrl_o.rd        = rd;
      ctrl_o.is_load   = (opc == OPC_LOAD);
      ctrl_o.is_jump   = is_jal | is_jalr;
      ctrl_o.is_branch = is_b;
      ctrl_o.funct3    = f3;
      if (is_r)                  ctrl_o.op = {instr_i[30], f3};
      else if (opc == OPC_OPIMM) ctrl_o.op = (f3 == 3'b101) ? {instr_i[30], f3} : {1'b0, f3};
      else if (opc == OPC_LUI)   ctrl_o.op = ALU_LUI;
      else                       ctrl_o.op = ALU_ADD;
      if (is_r || is_i || is_s || is_b || is_jalr) rs1_o = rs1;
      if (is_r || is_s || is_b)                    rs2_o = rs2;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipelined control for the 5-stage RV32I core (hazards, forwarding,
// EX branch resolution). Define PIPE_CTRL_FORWARD_EN to enable operand forwarding.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned REGW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       id_instr,
  input  logic              id_valid,
  input  logic              breq,
  input  logic              brlt,
  output logic              stall,
  output logic              flush,
  output logic              pcsel,
  output logic [IMMS_W-1:0] id_immsel,
  output logic              ex_asel,
  output logic              ex_bsel,
  output logic              ex_brun,
  output logic [OP_W-1:0]   ex_op,
  output logic [1:0]        ex_fwda,
  output logic [1:0]        ex_fwdb,
  output logic              mem_wren,
  output logic [2:0]        mem_rwsel,
  output logic              wb_regwen,
  output logic [1:0]        wb_wbsel,
  output logic [REGW-1:0]   wb_rd
);

  ctrl_t             id_ctrl, ex_d, ex_q, mem_q, wb_q;
  logic [REG_AW-1:0] id_rs1, id_rs2;
  logic              taken, hazard;
  logic              unused_bits;

  ctrl_decode #(.REGW(REGW)) u_decode (
    .instr_i  (id_instr),
    .valid_i  (id_valid),
    .ctrl_o   (id_ctrl),
    .immsel_o (id_immsel),
    .rs1_o    (id_rs1),
    .rs2_o    (id_rs2)
  );

  always_comb begin
    taken = 1'b0;
    case (ex_q.funct3)
      3'b000:         taken = breq;
      3'b001:         taken = ~breq;
      3'b100, 3'b110: taken = brlt;
      3'b101, 3'b111: taken = breq | ~brlt;
      default:        taken = 1'b0;
    endcase
  end

  assign pcsel = ex_q.valid & (ex_q.is_jump | (ex_q.is_branch & taken));
  assign flush = pcsel;
  assign stall = hazard & ~pcsel;

  // ID/EX takes a bubble on stall and on flush
  always_comb begin
    ex_d = id_ctrl;
    if (stall || flush) ex_d = CTRL_BUBBLE;
  end

`ifdef PIPE_CTRL_FORWARD_EN
  logic [REG_AW-1:0] ex_rs1_d, ex_rs1_q, ex_rs2_d, ex_rs2_q;

  assign hazard   = ex_q.is_load & (rd_match(id_rs1, ex_q) | rd_match(id_rs2, ex_q));
  assign ex_rs1_d = (stall || flush) ? '0 : id_rs1;
  assign ex_rs2_d = (stall || flush) ? '0 : id_rs2;
  assign ex_fwda  = fwd_sel(ex_rs1_q, mem_q, wb_q);
  assign ex_fwdb  = fwd_sel(ex_rs2_q, mem_q, wb_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_rs1_q <= '0;
      ex_rs2_q <= '0;
    end else begin
      ex_rs1_q <= ex_rs1_d;
      ex_rs2_q <= ex_rs2_d;
    end
  end
`else
  // write-through regfile covers a WB match; EX and MEM producers must drain
  assign hazard  = rd_match(id_rs1, ex_q)  | rd_match(id_rs2, ex_q) |
                   rd_match(id_rs1, mem_q) | rd_match(id_rs2, mem_q);
  assign ex_fwda = FWD_RF;
  assign ex_fwdb = FWD_RF;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= CTRL_BUBBLE;
      mem_q <= CTRL_BUBBLE;
      wb_q  <= CTRL_BUBBLE;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  assign ex_asel   = ex_q.asel;
  assign ex_bsel   = ex_q.bsel;
  assign ex_brun   = ex_q.brun;
  assign ex_op     = ex_q.op;
  assign mem_wren  = mem_q.wren;
  assign mem_rwsel = mem_q.rwsel;
  assign wb_regwen = wb_q.regwen;
  assign wb_wbsel  = wb_q.wbsel;
  assign wb_rd     = wb_q.rd[REGW-1:0];

  assign unused_bits = ^wb_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl; expectations follow the build's
// PIPE_CTRL_FORWARD_EN setting.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] id_instr;
  logic        id_valid, breq, brlt;
  logic        stall, flush, pcsel;
  logic [4:0]  id_immsel;
  logic        ex_asel, ex_bsel, ex_brun;
  logic [3:0]  ex_op;
  logic [1:0]  ex_fwda, ex_fwdb;
  logic        mem_wren;
  logic [2:0]  mem_rwsel;
  logic        wb_regwen;
  logic [1:0]  wb_wbsel;
  logic [4:0]  wb_rd;

  int n_vec = 0;
  int n_err = 0;

  pipe_ctrl #(.REGW(5)) dut (
    .clk(clk), .rst(rst), .id_instr(id_instr), .id_valid(id_valid),
    .breq(breq), .brlt(brlt), .stall(stall), .flush(flush), .pcsel(pcsel),
    .id_immsel(id_immsel), .ex_asel(ex_asel), .ex_bsel(ex_bsel),
    .ex_brun(ex_brun), .ex_op(ex_op), .ex_fwda(ex_fwda), .ex_fwdb(ex_fwdb),
    .mem_wren(mem_wren), .mem_rwsel(mem_rwsel), .wb_regwen(wb_regwen),
    .wb_wbsel(wb_wbsel), .wb_rd(wb_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // present ID inputs after the falling edge; outputs are sampled 1ns later
  task automatic cyc(input logic [31:0] ins, input logic v, input logic eq, input logic lt);
    @(negedge clk);
    id_instr = ins;
    id_valid = v;
    breq     = eq;
    brlt     = lt;
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) cyc(32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [4:0] rd);
    return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] btype(input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {7'b0, rs2, rs1, f3, 5'b0, 7'b1100011};
  endfunction

  logic [31:0] add1, sub4, lw1, add3, beq67, sub9, bge67, bgeu67, addi0, add5x0;
  logic [31:0] lui11, jal1, sw23, addi10;

  initial begin
    add1   = rtype(7'b0000000, 5'd3, 5'd2, 5'd1);
    sub4   = rtype(7'b0100000, 5'd5, 5'd1, 5'd4);
    lw1    = itype(12'd0, 5'd2, 3'b010, 5'd1, 7'b0000011);
    add3   = rtype(7'b0000000, 5'd1, 5'd1, 5'd3);
    beq67  = btype(5'd7, 5'd6, 3'b000);
    sub9   = rtype(7'b0100000, 5'd7, 5'd6, 5'd9);
    bge67  = btype(5'd7, 5'd6, 3'b101);
    bgeu67 = btype(5'd7, 5'd6, 3'b111);
    addi0  = itype(12'd1, 5'd0, 3'b000, 5'd0, 7'b0010011);
    add5x0 = rtype(7'b0000000, 5'd0, 5'd0, 5'd5);
    lui11  = {20'h12345, 5'd11, 7'b0110111};
    jal1   = {20'h00000, 5'd1, 7'b1101111};
    sw23   = {7'b0, 5'd2, 5'd3, 3'b010, 5'b0, 7'b0100011};
    addi10 = itype(12'd5, 5'd0, 3'b000, 5'd10, 7'b0010011);

    // reset state
    rst = 1'b1; id_instr = add1; id_valid = 1'b1; breq = 1'b1; brlt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_pcsel", pcsel, 0);
    chk("rst_flush", flush, 0);
    chk("rst_ex_bsel", ex_bsel, 0);
    chk("rst_mem_rwsel", mem_rwsel, 0);
    chk("rst_wb_regwen", wb_regwen, 0);
    chk("rst_immsel_r", id_immsel, 5'b00000);
    id_instr = lw1; #1;
    chk("rst_immsel_i", id_immsel, 5'b00001);
    @(negedge clk); rst = 1'b0;

    // add x1 then sub x4,x1,x5
    cyc(add1, 1, 0, 0);
    chk("a_stall0", stall, 0);
    cyc(sub4, 1, 0, 0);
    chk("a_ex_op_add", ex_op, 4'b0000);
    chk("a_ex_bsel_r", ex_bsel, 0);
`ifdef PIPE_CTRL_FORWARD_EN
    chk("a_stall1", stall, 0);
    cyc(32'h0, 0, 0, 0);
    chk("a_fwda", ex_fwda, 2'b01);
    chk("a_fwdb", ex_fwdb, 2'b00);
    chk("a_ex_op_sub", ex_op, 4'b1000);
    chk("a_stall2", stall, 0);
`else
    chk("a_stall1", stall, 1);
    cyc(sub4, 1, 0, 0);
    chk("a_stall2", stall, 1);
    chk("a_bubble_op", ex_op, 4'b0000);
    cyc(sub4, 1, 0, 0);
    chk("a_stall3", stall, 0);
    chk("a_wb_add_rd", wb_rd, 5'd1);
    cyc(32'h0, 0, 0, 0);
    chk("a_ex_op_sub", ex_op, 4'b1000);
    chk("a_fwda", ex_fwda, 2'b00);
`endif
    drain();

    // lw x1 then add x3,x1,x1
    cyc(lw1, 1, 0, 0);
    chk("b_immsel", id_immsel, 5'b00001);
    cyc(add3, 1, 0, 0);
    chk("b_stall", stall, 1);
    chk("b_ex_bsel", ex_bsel, 1);
    cyc(add3, 1, 0, 0);
    chk("b_mem_rwsel", mem_rwsel, 3'b010);
    chk("b_bubble_bsel", ex_bsel, 0);
`ifdef PIPE_CTRL_FORWARD_EN
    chk("b_stall_once", stall, 0);
    cyc(32'h0, 0, 0, 0);
    chk("b_fwda", ex_fwda, 2'b10);
    chk("b_fwdb", ex_fwdb, 2'b10);
`else
    chk("b_stall_mem", stall, 1);
    cyc(add3, 1, 0, 0);
    chk("b_stall_done", stall, 0);
`endif
    chk("b_wb_wbsel", wb_wbsel, 2'b00);
    chk("b_wb_regwen", wb_regwen, 1);
    chk("b_wb_rd", wb_rd, 5'd1);
    drain();

    // beq taken: flush and two bubbles
    cyc(beq67, 1, 0, 0);
    chk("c_immsel", id_immsel, 5'b00100);
    cyc(sub9, 1, 1, 0);
    chk("c_pcsel", pcsel, 1);
    chk("c_flush", flush, 1);
    chk("c_stall", stall, 0);
    chk("c_asel", ex_asel, 1);
    chk("c_brun", ex_brun, 0);
    cyc(32'h0, 0, 0, 0);
    chk("c_bub1_op", ex_op, 4'b0000);
    chk("c_pcsel_off", pcsel, 0);
    cyc(32'h0, 0, 0, 0);
    chk("c_bub2_op", ex_op, 4'b0000);
    chk("c_wb_beq", wb_regwen, 0);
    cyc(32'h0, 0, 0, 0);
    chk("c_wb_killed", wb_regwen, 0);
    drain();

    // bge / bgeu resolution
    cyc(bge67, 1, 0, 0);
    cyc(bgeu67, 1, 0, 1);
    chk("d_bge_lt", pcsel, 0);
    chk("d_bge_brun", ex_brun, 0);
    cyc(32'h0, 0, 1, 0);
    chk("d_bgeu_eq", pcsel, 1);
    chk("d_bgeu_brun", ex_brun, 1);
    drain();

    // write to x0 then read of x0
    cyc(addi0, 1, 0, 0);
    cyc(add5x0, 1, 0, 0);
    chk("e_stall_x0", stall, 0);
    chk("e_op_addi", ex_op, 4'b0000);
    cyc(32'h0, 0, 0, 0);
    chk("e_fwda_x0", ex_fwda, 2'b00);
    chk("e_fwdb_x0", ex_fwdb, 2'b00);
    cyc(32'h0, 0, 0, 0);
    chk("e_wb_regwen_x0", wb_regwen, 0);
    drain();

    // lui, jal and store fields
    cyc(lui11, 1, 0, 0);
    chk("f_immsel_u", id_immsel, 5'b01000);
    cyc(jal1, 1, 0, 0);
    chk("f_lui_op", ex_op, 4'b1001);
    chk("f_immsel_j", id_immsel, 5'b10000);
    cyc(sw23, 1, 0, 0);
    chk("f_jal_pcsel", pcsel, 1);
    cyc(32'h0, 0, 0, 0);
    chk("f_sw_flushed_op", ex_op, 4'b0000);
    cyc(32'h0, 0, 0, 0);
    chk("f_jal_wbsel", wb_wbsel, 2'b10);
    chk("f_jal_rd", wb_rd, 5'd1);
    drain();
    cyc(sw23, 1, 0, 0);
    chk("f_immsel_s", id_immsel, 5'b00010);
    cyc(32'h0, 0, 0, 0);
    cyc(32'h0, 0, 0, 0);
    chk("f_sw_wren", mem_wren, 1);
    chk("f_sw_rwsel", mem_rwsel, 3'b010);
    drain();

    // reset during a load-use stall
    cyc(lw1, 1, 0, 0);
    cyc(add3, 1, 0, 0);
    chk("g_stall_pre", stall, 1);
    rst = 1'b1; #1;
    chk("g_rst_stall", stall, 0);
    chk("g_rst_bsel", ex_bsel, 0);
    chk("g_rst_pcsel", pcsel, 0);
    cyc(addi10, 1, 0, 0);
    rst = 1'b0;
    cyc(32'h0, 0, 0, 0);
    chk("g_post_bsel", ex_bsel, 1);
    chk("g_post_stall", stall, 0);
    cyc(32'h0, 0, 0, 0);
    cyc(32'h0, 0, 0, 0);
    chk("g_post_wb_rd", wb_rd, 5'd10);
    chk("g_post_wb_regwen", wb_regwen, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
